// File: rtl/pdp8_mem_pkg.sv
// Shared encodings and widths for the PDP-8 memory-cycle sequencer.
package pdp8_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int WORD_W = 12;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_RIW = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    INC,
    WS,
    WP,
    WH,
    DONE
  } state_e;

endpackage

// File: rtl/pdp8_mem_seq_if.sv
// Request/acknowledge bus between a CPU/DMA requester and the memory sequencer.
interface pdp8_mem_seq_if;
  import pdp8_mem_pkg::*;

  logic              req;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;
  logic              skip;
  logic              busy;

  modport master (
    output req, op, addr, wdata,
    input  ack, rdata, skip, busy
  );

  modport slave (
    input  req, op, addr, wdata,
    output ack, rdata, skip, busy
  );

endinterface

// File: rtl/pdp8_mem_timer.sv
// Loadable down-counter that times every setup/pulse/hold phase of a memory cycle.
module pdp8_mem_timer
  import pdp8_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pdp8_mem_seq.sv
// Memory-cycle sequencer in front of pdp8_ram: read, write and atomic
// read-increment-write with programmable async-SRAM strobe timing.
module pdp8_mem_seq
  import pdp8_mem_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_SETUP  = 1,
  parameter int unsigned WR_PULSE  = 2,
  parameter int unsigned WR_HOLD   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  pdp8_mem_seq_if.slave     bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data_in,
  input  logic [WORD_W-1:0] ram_data_out,
  output logic              ram_rd,
  output logic              ram_wr
);

  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WS_LD = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_LD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] WH_LD = CNT_W'(WR_HOLD - 1);

  function automatic logic [WORD_W-1:0] incr_word(input logic [WORD_W-1:0] v);
    return v + WORD_W'(1);
  endfunction

  state_e            state, state_n;
  op_e               op_q;
  logic [WORD_W-1:0] cap;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;

  pdp8_mem_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          tmr_load = 1'b1;
          if (op_e'(bus.op) == OP_WR) begin
            state_n = WS;
            tmr_val = WS_LD;
          end else begin
            state_n = RD;
            tmr_val = RD_LD;
          end
        end
      end
      RD:   if (tmr_zero) state_n = (op_q == OP_RIW) ? INC : DONE;
      INC: begin
        state_n  = WS;
        tmr_load = 1'b1;
        tmr_val  = WS_LD;
      end
      WS: begin
        if (tmr_zero) begin
          state_n  = WP;
          tmr_load = 1'b1;
          tmr_val  = WP_LD;
        end
      end
      WP: begin
        if (tmr_zero) begin
          state_n  = WH;
          tmr_load = 1'b1;
          tmr_val  = WH_LD;
        end
      end
      WH:      if (tmr_zero) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= OP_RD;
      bus.ack     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.skip    <= 1'b0;
      bus.rdata   <= '0;
      ram_rd      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      state    <= state_n;
      bus.ack  <= (state_n == DONE);
      bus.busy <= (state_n != IDLE);
      ram_rd   <= (state_n == RD);
      ram_wr   <= (state_n == WP);
      if (state == IDLE && bus.req) begin
        ram_addr    <= bus.addr;
        ram_data_in <= bus.wdata;
        op_q        <= op_e'(bus.op);
      end
      if (state == RD && tmr_zero && op_q != OP_RIW) begin
        bus.rdata <= ram_data_out;
      end
      if (state == INC) begin
        ram_data_in <= incr_word(cap);
        bus.rdata   <= incr_word(cap);
        bus.skip    <= (cap == 12'o7777);
      end
    end
  end

  // RIW holds the fetched word here so rdata stays stable until the ack.
  always_ff @(posedge clk) begin
    if (state == RD && tmr_zero) begin
      cap <= ram_data_out;
    end
  end

endmodule

// File: tb/tb_pdp8_mem_seq.sv
// Self-checking bench for pdp8_mem_seq with a behavioural SRAM behind each instance.
module tb_pdp8_mem_seq;

  localparam int RDC = 2, WSU = 1, WPL = 2, WHD = 1;
  localparam logic [1:0] O_RD = 2'b00, O_WR = 2'b01, O_RIW = 2'b10, O_RSV = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 1: default timing ----------------
  pdp8_mem_seq_if bus();
  logic [14:0] r_addr1;
  logic [11:0] r_din1, r_dout1;
  logic        r_rd1, r_wr1;
  logic [11:0] mem1 [32768];
  assign r_dout1 = mem1[r_addr1];
  always @(posedge clk) if (r_wr1) mem1[r_addr1] <= r_din1;

  pdp8_mem_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .ram_addr     (r_addr1),
    .ram_data_in  (r_din1),
    .ram_data_out (r_dout1),
    .ram_rd       (r_rd1),
    .ram_wr       (r_wr1)
  );

  // ---------------- DUT 2: swept timing ----------------
  pdp8_mem_seq_if bus2();
  logic [14:0] r_addr2;
  logic [11:0] r_din2, r_dout2;
  logic        r_rd2, r_wr2;
  logic [11:0] mem2 [32768];
  assign r_dout2 = mem2[r_addr2];
  always @(posedge clk) if (r_wr2) mem2[r_addr2] <= r_din2;

  pdp8_mem_seq #(.RD_CYCLES(1), .WR_SETUP(3), .WR_PULSE(1), .WR_HOLD(2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus2),
    .ram_addr     (r_addr2),
    .ram_data_in  (r_din2),
    .ram_data_out (r_dout2),
    .ram_rd       (r_rd2),
    .ram_wr       (r_wr2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe overlap is forbidden on both instances at all times.
  always @(negedge clk) begin
    checks++;
    if ((r_rd1 && r_wr1) || (r_rd2 && r_wr2)) begin
      errors++;
      $display("FAIL rd_wr_overlap: rd1=%0b wr1=%0b rd2=%0b wr2=%0b", r_rd1, r_wr1, r_rd2, r_wr2);
    end
  end

  // Results of the most recent DUT1 transaction; cycle 1 is the first busy cycle.
  int          t_lat, t_base, t_rd_lo, t_rd_hi, t_wr_lo, t_wr_hi, t_addr_bad;
  logic [11:0] t_rdata;
  logic        t_skip;

  task automatic do_txn(input logic [1:0] o, input logic [14:0] a, input logic [11:0] w);
    int cyc;
    bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = w;
    t_lat = -1; t_base = -1; t_rd_lo = 0; t_rd_hi = 0; t_wr_lo = 0; t_wr_hi = 0; t_addr_bad = 0;
    for (int n = 1; n <= 60 && t_lat < 0; n++) begin
      @(negedge clk);
      if (t_base < 0 && bus.busy) t_base = n - 1;
      if (t_base >= 0) begin
        cyc = n - t_base;
        if (r_addr1 !== a) t_addr_bad++;
        if (r_rd1) begin if (t_rd_lo == 0) t_rd_lo = cyc; t_rd_hi = cyc; end
        if (r_wr1) begin if (t_wr_lo == 0) t_wr_lo = cyc; t_wr_hi = cyc; end
        if (bus.ack) begin
          t_lat = cyc; t_rdata = bus.rdata; t_skip = bus.skip;
          bus.req = 1'b0;
        end
      end
    end
    bus.req = 1'b0;
    if (t_lat < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn2(input logic [1:0] o, input logic [14:0] a, input logic [11:0] w,
                      output int lat, output logic [11:0] rd);
    bus2.req = 1'b1; bus2.op = o; bus2.addr = a; bus2.wdata = w;
    lat = -1; rd = '0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (bus2.ack) begin lat = n; rd = bus2.rdata; bus2.req = 1'b0; end
    end
    bus2.req = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [14:0] addr;
    logic [11:0] wdata;
    logic [11:0] rdata;
    logic        skip;
    int          lat;
    int          rd_lo, rd_hi, wr_lo, wr_hi;
  } vec_t;

  vec_t vt[12];

  // Reference model state for the randomized phase.
  logic [11:0] ref_mem [logic [14:0]];
  logic [11:0] ref_rdata;
  logic        ref_skip;
  logic [14:0] pool [4];

  function automatic logic [11:0] ref_read(input logic [14:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 12'o0000;
  endfunction

  initial begin
    int          acks, lat2, exp_lat;
    logic        seen, saw_wr;
    logic [1:0]  o;
    logic [14:0] a;
    logic [11:0] w, rd2, v;

    for (int i = 0; i < 32768; i++) begin mem1[i] = '0; mem2[i] = '0; end
    bus.req = 0; bus.op = 0; bus.addr = 0; bus.wdata = 0;
    bus2.req = 0; bus2.op = 0; bus2.addr = 0; bus2.wdata = 0;

    vt[0]  = '{O_WR,  15'o00100, 12'o1234, 12'o0000, 1'b0, 5, 0, 0, 2, 3};
    vt[1]  = '{O_RD,  15'o00100, 12'o0000, 12'o1234, 1'b0, 3, 1, 2, 0, 0};
    vt[2]  = '{O_WR,  15'o00010, 12'o0005, 12'o1234, 1'b0, 5, 0, 0, 2, 3};
    vt[3]  = '{O_RIW, 15'o00010, 12'o0000, 12'o0006, 1'b0, 8, 1, 2, 5, 6};
    vt[4]  = '{O_RD,  15'o00010, 12'o0000, 12'o0006, 1'b0, 3, 1, 2, 0, 0};
    vt[5]  = '{O_WR,  15'o70000, 12'o7777, 12'o0006, 1'b0, 5, 0, 0, 2, 3};
    vt[6]  = '{O_RIW, 15'o70000, 12'o0000, 12'o0000, 1'b1, 8, 1, 2, 5, 6};
    vt[7]  = '{O_RD,  15'o70000, 12'o0000, 12'o0000, 1'b1, 3, 1, 2, 0, 0};
    vt[8]  = '{O_WR,  15'o00020, 12'o4321, 12'o0000, 1'b1, 5, 0, 0, 2, 3};
    vt[9]  = '{O_RSV, 15'o00020, 12'o0000, 12'o4321, 1'b1, 3, 1, 2, 0, 0};
    vt[10] = '{O_RIW, 15'o70000, 12'o0000, 12'o0001, 1'b0, 8, 1, 2, 5, 6};
    vt[11] = '{O_RIW, 15'o00020, 12'o0000, 12'o4322, 1'b0, 8, 1, 2, 5, 6};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ack", bus.ack, 0);       chk("rst_busy", bus.busy, 0);
    chk("rst_rd", r_rd1, 0);          chk("rst_wr", r_wr1, 0);
    chk("rst_skip", bus.skip, 0);     chk("rst_addr", r_addr1, 0);
    chk("rst_din", r_din1, 0);        chk("rst_rdata", bus.rdata, 0);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      do_txn(vt[i].op, vt[i].addr, vt[i].wdata);
      chk($sformatf("v%0d_accept", i), t_base, 0);
      chk($sformatf("v%0d_lat", i), t_lat, vt[i].lat);
      chk($sformatf("v%0d_rdata", i), t_rdata, vt[i].rdata);
      chk($sformatf("v%0d_skip", i), t_skip, vt[i].skip);
      chk($sformatf("v%0d_rd_win", i), {t_rd_lo[15:0], t_rd_hi[15:0]}, {vt[i].rd_lo[15:0], vt[i].rd_hi[15:0]});
      chk($sformatf("v%0d_wr_win", i), {t_wr_lo[15:0], t_wr_hi[15:0]}, {vt[i].wr_lo[15:0], vt[i].wr_hi[15:0]});
      chk($sformatf("v%0d_addr_stable", i), t_addr_bad, 0);
    end
    chk("mem_00010", mem1[15'o00010], 12'o0006);
    chk("mem_70000", mem1[15'o70000], 12'o0001);

    // req toggled while busy: exactly one ack
    @(negedge clk);
    bus.req = 1'b1; bus.op = O_RD; bus.addr = 15'o00100;
    acks = 0; seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.ack) begin acks++; bus.req = 1'b0; seen = 1'b1; chk("hs_rdata", bus.rdata, 12'o1234); end
      else if (!seen) bus.req = ~bus.req;
    end
    bus.req = 1'b0;
    chk("hs_one_ack", acks, 1);

    // Back-to-back requests
    @(negedge clk);
    do_txn(O_RD, 15'o00010, 12'o0000);
    chk("b2b_first_accept", t_base, 0);
    do_txn(O_RD, 15'o70000, 12'o0000);
    chk("b2b_second_accept", t_base, 1);
    chk("b2b_lat", t_lat, 3);
    chk("b2b_rdata", t_rdata, 12'o0001);
    chk("b2b_addr_stable", t_addr_bad, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 4; i++) pool[i] = 15'o40000 + 15'($urandom_range(0, 4095));
    ref_skip = 1'b0;
    ref_rdata = '0;
    for (int i = 0; i < 40; i++) begin
      o = (i == 0) ? O_RIW : 2'($urandom_range(0, 3));
      a = pool[$urandom_range(0, 3)];
      w = ($urandom_range(0, 3) == 0) ? 12'o7777 : 12'($urandom);
      case (o)
        O_WR: begin
          ref_mem[a] = w;
          exp_lat = WSU + WPL + WHD + 1;
        end
        O_RIW: begin
          v = 12'((int'(ref_read(a)) + 1) % 4096);
          ref_mem[a] = v; ref_rdata = v; ref_skip = (v == 12'o0000);
          exp_lat = RDC + 1 + WSU + WPL + WHD + 1;
        end
        default: begin
          ref_rdata = ref_read(a);
          exp_lat = RDC + 1;
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(o, a, w);
      chk($sformatf("rnd%0d_lat", i), t_lat, exp_lat);
      chk($sformatf("rnd%0d_rdata", i), t_rdata, ref_rdata);
      chk($sformatf("rnd%0d_skip", i), t_skip, ref_skip);
    end

    // Reset in the middle of the write pulse
    @(negedge clk);
    bus.req = 1'b1; bus.op = O_WR; bus.addr = 15'o00200; bus.wdata = 12'o5555;
    saw_wr = 1'b0;
    for (int n = 1; n <= 10 && !saw_wr; n++) begin
      @(negedge clk);
      if (r_wr1) saw_wr = 1'b1;
    end
    chk("mid_saw_wr", saw_wr, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_wr", r_wr1, 0);          chk("mid_rd", r_rd1, 0);
    chk("mid_ack", bus.ack, 0);       chk("mid_busy", bus.busy, 0);
    chk("mid_skip", bus.skip, 0);     chk("mid_addr", r_addr1, 0);
    chk("mid_din", r_din1, 0);        chk("mid_rdata", bus.rdata, 0);
    bus.req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mid_no_ack", bus.ack, 0);
    reset_n = 1'b1;
    do_txn(O_RD, 15'o00100, 12'o0000);
    chk("post_rst_accept", t_base, 0);
    chk("post_rst_lat", t_lat, 3);
    chk("post_rst_rdata", t_rdata, 12'o1234);

    // Alternate timing instance
    @(negedge clk);
    txn2(O_WR, 15'o00300, 12'o1234, lat2, rd2);
    chk("sweep_wr_lat", lat2, 7);
    @(negedge clk);
    txn2(O_RD, 15'o00300, 12'o0000, lat2, rd2);
    chk("sweep_rd_lat", lat2, 2);
    chk("sweep_rd_data", rd2, 12'o1234);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdp8_mem_seq.md
Name: pdp8_mem_seq

Overview:
Memory-cycle sequencer directly upstream of pdp8_ram. It accepts one CPU/DMA memory request at a time through a req/ack handshake. It drives pdp8_ram's addr/data_in/rd/wr with parameterised setup/pulse/hold timing for the async SRAM and captures data_out. It also supports an atomic read-increment-write operation, used for PDP-8 ISZ and autoindex.

Parameters:
RD_CYCLES, 2, cycles ram_rd is held high; data sampled on the last one (range 1..15)
WR_SETUP, 1, cycles addr/data are driven before ram_wr rises (range 1..15)
WR_PULSE, 2, cycles ram_wr is held high (range 1..15)
WR_HOLD, 1, cycles addr/data are held after ram_wr falls (range 1..15)

Ports:
clk  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  1  request; sampled only in IDLE; requester holds req/op/addr/wdata until ack
op  in  2  00 read, 01 write, 10 read-increment-write, 11 reserved (executed as read)
addr  in  15  field+address
wdata  in  12  write data (op 01)
ack  out  1  one-cycle completion pulse
rdata  out  12  read data (op 00/11) or incremented value (op 10); valid from ack, held until the next ack
skip  out  1  op 10 result == 0; valid from ack, held until the next ack
busy  out  1  high from the cycle after acceptance through the ack cycle
ram_addr  out  15  to pdp8_ram addr
ram_data_in  out  12  to pdp8_ram data_in
ram_data_out  in  12  from pdp8_ram data_out
ram_rd  out  1  to pdp8_ram rd
ram_wr  out  1  to pdp8_ram wr

Behaviour:
- Reset (async, reset_n=0): state IDLE; ack, busy, ram_rd, ram_wr, skip = 0; ram_addr, ram_data_in, rdata = 0.
- Reset mid-cycle: ram_rd/ram_wr drop immediately (asynchronous). The request is lost, no ack is issued, and the requester re-issues after reset.
- All outputs are registered. ram_rd and ram_wr are never high together.
- Cycle 0 is the cycle in which req=1 is sampled in IDLE. At that edge, addr/op/wdata are latched into ram_addr, ram_data_in and the op register, and the FSM leaves IDLE.
- ram_addr and ram_data_in stay constant from acceptance to the end of the ack cycle. In IDLE they hold their last values.
- States:
  - IDLE: waiting for req.
  - RD: ram_rd=1 for RD_CYCLES cycles; ram_data_out is captured at the edge ending the last RD cycle.
  - INC: op 10 only, 1 cycle. ram_data_in <= captured+1 mod 4096; skip <= (captured == 12'o7777).
  - WS: ram_wr=0 for WR_SETUP cycles.
  - WP: ram_wr=1 for WR_PULSE cycles.
  - WH: ram_wr=0 for WR_HOLD cycles.
  - DONE: ack=1 for 1 cycle, then IDLE.
- State sequences by op:
  - Read (00/11): IDLE→RD→DONE; ack in cycle RD_CYCLES+1; rdata = captured value; skip unchanged.
  - Write (01): IDLE→WS→WP→WH→DONE; ack in cycle WR_SETUP+WR_PULSE+WR_HOLD+1; rdata and skip unchanged.
  - RIW (10): IDLE→RD→INC→WS→WP→WH→DONE; rdata = incremented value; skip as computed in INC.
- req is ignored outside IDLE. Because DONE always returns to IDLE, back-to-back requests have a minimum gap of one cycle. A requester that samples ack and clears req at the same edge produces no duplicate request.
- Increment wraps: 7777 → 0000 with skip=1. Otherwise skip=0.
- Timing counter is 4 bits. It is loaded with (N-1) on entry to each timed state, and the state advances when the counter reaches 0.

Decomposition:
- Package pdp8_mem_pkg:
  - op encodings (OP_RD, OP_WR, OP_RIW)
  - FSM state enum (IDLE, RD, INC, WS, WP, WH, DONE)
  - widths ADDR_W=15, WORD_W=12, CNT_W=4
- Sub-module pdp8_mem_timer: loadable 4-bit down-counter with a zero flag, shared by all timed states.
- The FSM and datapath stay in pdp8_mem_seq.

Test Plan (default parameters; pdp8_ram sim model behind the block):
- Write then read: write 12'o1234 @ 15'o00100 → ram_wr high exactly cycles 2–3, ack cycle 5. Then read @ 15'o00100 → ram_rd high cycles 1–2, ack cycle 3, rdata=1234.
- RIW no wrap: memory 12'o0005 @ 15'o00010 → ack cycle 8, rdata=0006, skip=0, and a subsequent read returns 0006.
- RIW wrap: memory 12'o7777 @ 15'o70000 → rdata=0000, skip=1, and memory now holds 0000.
- Handshake: req held across a long read, with a new req toggled while busy → exactly one ack per accepted request. Back-to-back requests are accepted two cycles apart and ram_addr is stable throughout each cycle.
- Reset mid-write: assert reset_n=0 during WP → ram_wr falls without waiting for a clock edge, no ack, all outputs zero. After release the block is IDLE, accepts a read in the next cycle, and acks it at cycle 3.
- Parameter sweep: RD_CYCLES=1/WR_SETUP=3/WR_PULSE=1/WR_HOLD=2 → read ack cycle 2, write ack cycle 7, rd/wr never overlap.
